// File: rtl/drive_slew_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : drive_slew_pkg                                               |
// | Description : Shared types, widths and helpers for the drive slew          |
// |               sequencer (drive sample type, FSM states, target clamp).     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package drive_slew_pkg;

   // Native width of one duty/phase/cycle sample.
   localparam int DRIVE_W = 13;

   typedef logic [DRIVE_W-1:0] drive_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   // Source-select width; a single source still gets a 1-bit select port.
   function automatic int sel_width(input int n_src);
      return (n_src > 1) ? $clog2(n_src) : 1;
   endfunction

   localparam int SEL_W = sel_width(2);

   // Saturate a target to an inclusive upper limit.
   function automatic int unsigned clamp_target(input int unsigned tgt,
                                                input int unsigned lim);
      return (tgt > lim) ? lim : tgt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/drive_slew_sequencer_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : slew_step_unit                                               |
// | Description : Purely combinational one-channel duty + phase slew step.    |
// |               Clamps targets to the channel period, then moves duty        |
// |               linearly and phase along the shortest modular path, by at    |
// |               most STEP each. bypass jumps straight to the clamped target.|
// | Ports       : cur_duty/cur_phase  current registered values                |
// |               tgt_duty/tgt_phase  raw targets from the selected source     |
// |               cycle               channel period                           |
// |               step                max change per pass                      |
// |               bypass              write clamped targets directly           |
// |               nxt_duty/nxt_phase  values to write back                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module slew_step_unit
   import drive_slew_pkg::*;
#(
   parameter int WIDTH = DRIVE_W
) (
   input  logic [WIDTH-1:0] cur_duty,
   input  logic [WIDTH-1:0] cur_phase,
   input  logic [WIDTH-1:0] tgt_duty,
   input  logic [WIDTH-1:0] tgt_phase,
   input  logic [WIDTH-1:0] cycle,
   input  logic [WIDTH-1:0] step,
   input  logic             bypass,
   output logic [WIDTH-1:0] nxt_duty,
   output logic [WIDTH-1:0] nxt_phase
);

   logic [WIDTH-1:0]        half;
   logic [WIDTH-1:0]        phase_lim;
   logic [WIDTH-1:0]        duty_tc;
   logic [WIDTH-1:0]        phase_tc;
   logic [WIDTH-1:0]        cur_ph;
   logic signed [WIDTH:0]   d_diff;
   logic [WIDTH:0]          d_mag;
   logic [WIDTH:0]          ph_diff;
   logic [WIDTH:0]          ph_back;
   logic [WIDTH:0]          adv;
   logic [WIDTH:0]          ret;
   logic [WIDTH:0]          ph_sum;

   always_comb begin
      half      = cycle >> 1;
      phase_lim = (cycle == '0) ? '0 : cycle - WIDTH'(1);

      duty_tc   = WIDTH'(clamp_target(32'(tgt_duty), 32'(half)));
      phase_tc  = WIDTH'(clamp_target(32'(tgt_phase), 32'(phase_lim)));

      // ---------------- duty: linear slew ----------------
      d_diff = $signed({1'b0, duty_tc}) - $signed({1'b0, cur_duty});
      d_mag  = d_diff[WIDTH] ? $unsigned(-d_diff) : $unsigned(d_diff);

      if (bypass || (d_mag <= {1'b0, step})) begin
         nxt_duty = duty_tc;
      end else if (!d_diff[WIDTH]) begin
         nxt_duty = cur_duty + step;
      end else begin
         nxt_duty = cur_duty - step;
      end

      // ---------------- phase: shortest modular path ----------------
      // A phase left out of range by a shrinking period is pulled to the top
      // of the new range so the modular distance below stays well defined.
      cur_ph  = (cur_phase >= cycle) ? phase_lim : cur_phase;

      ph_diff = (phase_tc >= cur_ph) ? ({1'b0, phase_tc} - {1'b0, cur_ph})
                                     : ({1'b0, phase_tc} + {1'b0, cycle} - {1'b0, cur_ph});
      ph_back = {1'b0, cycle} - ph_diff;
      adv     = (ph_diff < {1'b0, step}) ? ph_diff : {1'b0, step};
      ret     = (ph_back < {1'b0, step}) ? ph_back : {1'b0, step};
      ph_sum  = {1'b0, cur_ph} + adv;

      if (bypass) begin
         nxt_phase = phase_tc;
      end else if (ph_diff == '0) begin
         nxt_phase = cur_ph;
      end else if (ph_diff <= {1'b0, half}) begin
         // Exactly half a cycle lands here: ties go positive.
         nxt_phase = (ph_sum >= {1'b0, cycle}) ? WIDTH'(ph_sum - {1'b0, cycle})
                                               : WIDTH'(ph_sum);
      end else begin
         nxt_phase = ({1'b0, cur_ph} >= ret) ? WIDTH'({1'b0, cur_ph} - ret)
                                             : WIDTH'({1'b0, cur_ph} + {1'b0, cycle} - ret);
      end
   end

endmodule
`default_nettype wire

// File: rtl/drive_slew_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : drive_slew_sequencer                                         |
// | Description : Selects one of N_SRC drive sources and slew-limits every     |
// |               channel's duty and phase toward it, one channel per clock    |
// |               through a shared two-stage datapath (fetch, step+write).     |
// | Config      : DRIVE_SLEW_PASSTHROUGH_EN adds input bypass; when sampled    |
// |               high with update, the pass writes clamped targets directly.  |
// | Ports       : clk, rst_n (async, active-low)                               |
// |               update    1-cycle pulse starting a pass                      |
// |               src_sel   source index (out of range -> source 0)            |
// |               step      max change per pass                                |
// |               cycle     per-channel period                                 |
// |               duty_in/phase_in  targets per channel and source             |
// |               duty_out/phase_out  registered slewed values                 |
// |               busy, done (pass complete), overrun (update dropped)         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module drive_slew_sequencer
   import drive_slew_pkg::*;
#(
   parameter  int WIDTH = $bits(drive_t),
   parameter  int DEPTH = 249,
   parameter  int N_SRC = 2,
   localparam int SRC_W = sel_width(N_SRC),
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                                clk,
   input  logic                                rst_n,
`ifdef DRIVE_SLEW_PASSTHROUGH_EN
   input  logic                                bypass,
`endif
   input  logic                                update,
   input  logic [SRC_W-1:0]                    src_sel,
   input  logic [WIDTH-1:0]                    step,
   input  logic [DEPTH-1:0][WIDTH-1:0]         cycle,
   input  logic [DEPTH-1:0][N_SRC-1:0][WIDTH-1:0] duty_in,
   input  logic [DEPTH-1:0][N_SRC-1:0][WIDTH-1:0] phase_in,
   output logic [DEPTH-1:0][WIDTH-1:0]         duty_out,
   output logic [DEPTH-1:0][WIDTH-1:0]         phase_out,
   output logic                                busy,
   output logic                                done,
   output logic                                overrun
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   state_t                     state_q,  state_d;
   logic [IDX_W-1:0]           idx_q,    idx_d;
   logic                       busy_q,   busy_d;
   logic                       done_q,   done_d;
   logic                       overrun_q, overrun_d;
   logic [SRC_W-1:0]           sel_q,    sel_d;
   logic [WIDTH-1:0]           step_q,   step_d;
   logic                       bypass_q, bypass_d;

   // Stage-1 (fetch) registers feeding the step unit.
   logic                       s1_vld_q,       s1_vld_d;
   logic [IDX_W-1:0]           s1_idx_q,       s1_idx_d;
   logic [WIDTH-1:0]           s1_cycle_q,     s1_cycle_d;
   logic [WIDTH-1:0]           s1_tgt_duty_q,  s1_tgt_duty_d;
   logic [WIDTH-1:0]           s1_tgt_phase_q, s1_tgt_phase_d;
   logic [WIDTH-1:0]           s1_cur_duty_q,  s1_cur_duty_d;
   logic [WIDTH-1:0]           s1_cur_phase_q, s1_cur_phase_d;

   logic [DEPTH-1:0][WIDTH-1:0] duty_q,  duty_d;
   logic [DEPTH-1:0][WIDTH-1:0] phase_q, phase_d;

   logic [WIDTH-1:0]           nxt_duty;
   logic [WIDTH-1:0]           nxt_phase;

   // Stage 2: one shared step unit serves every channel in turn.
   slew_step_unit #(
      .WIDTH (WIDTH)
   ) u_step (
      .cur_duty  (s1_cur_duty_q),
      .cur_phase (s1_cur_phase_q),
      .tgt_duty  (s1_tgt_duty_q),
      .tgt_phase (s1_tgt_phase_q),
      .cycle     (s1_cycle_q),
      .step      (step_q),
      .bypass    (bypass_q),
      .nxt_duty  (nxt_duty),
      .nxt_phase (nxt_phase)
   );

   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      busy_d         = busy_q;
      done_d         = 1'b0;
      // busy_q stays high through the DONE cycle, so an update there is dropped too.
      overrun_d      = update & busy_q;
      sel_d          = sel_q;
      step_d         = step_q;
      bypass_d       = bypass_q;
      s1_vld_d       = 1'b0;
      s1_idx_d       = s1_idx_q;
      s1_cycle_d     = s1_cycle_q;
      s1_tgt_duty_d  = s1_tgt_duty_q;
      s1_tgt_phase_d = s1_tgt_phase_q;
      s1_cur_duty_d  = s1_cur_duty_q;
      s1_cur_phase_d = s1_cur_phase_q;
      duty_d         = duty_q;
      phase_d        = phase_q;

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (update && !busy_q) begin
               state_d = RUN;
               idx_d   = '0;
               busy_d  = 1'b1;
               sel_d   = (32'(src_sel) < N_SRC) ? src_sel : '0;
               step_d  = step;
`ifdef DRIVE_SLEW_PASSTHROUGH_EN
               bypass_d = bypass;
`else
               bypass_d = 1'b0;
`endif
            end
         end
         RUN: begin
            s1_vld_d       = 1'b1;
            s1_idx_d       = idx_q;
            s1_cycle_d     = cycle[idx_q];
            s1_tgt_duty_d  = duty_in[idx_q][sel_q];
            s1_tgt_phase_d = phase_in[idx_q][sel_q];
            s1_cur_duty_d  = duty_q[idx_q];
            s1_cur_phase_d = phase_q[idx_q];
            if (idx_q == LAST_IDX) begin
               state_d = FLUSH;
               idx_d   = '0;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
            end
         end
         FLUSH: begin
            // The last channel is written on this edge, so outputs are
            // complete in the cycle DONE is visible.
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (s1_vld_q) begin
         duty_d[s1_idx_q]  = nxt_duty;
         phase_d[s1_idx_q] = nxt_phase;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         idx_q          <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         overrun_q      <= 1'b0;
         sel_q          <= '0;
         step_q         <= '0;
         bypass_q       <= 1'b0;
         s1_vld_q       <= 1'b0;
         s1_idx_q       <= '0;
         s1_cycle_q     <= '0;
         s1_tgt_duty_q  <= '0;
         s1_tgt_phase_q <= '0;
         s1_cur_duty_q  <= '0;
         s1_cur_phase_q <= '0;
         duty_q         <= '0;
         phase_q        <= '0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         overrun_q      <= overrun_d;
         sel_q          <= sel_d;
         step_q         <= step_d;
         bypass_q       <= bypass_d;
         s1_vld_q       <= s1_vld_d;
         s1_idx_q       <= s1_idx_d;
         s1_cycle_q     <= s1_cycle_d;
         s1_tgt_duty_q  <= s1_tgt_duty_d;
         s1_tgt_phase_q <= s1_tgt_phase_d;
         s1_cur_duty_q  <= s1_cur_duty_d;
         s1_cur_phase_q <= s1_cur_phase_d;
         duty_q         <= duty_d;
         phase_q        <= phase_d;
      end
   end

   assign duty_out  = duty_q;
   assign phase_out = phase_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign overrun   = overrun_q;

endmodule
`default_nettype wire
